bfp16_mult_arbiter: RTL and testbench
=====================================

BFP16_MULT_ARBITER -- requirements
Module: bfp16_mult_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  N_REQ  per-requester operand valid.
REQ-006 Port: req_a / req_b  input  16*N_REQ each  flattened BF16 operands, requester i at bits [16i+15:16i].
REQ-007 Port: req_ready  output  N_REQ  one-hot grant; an operand pair transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 Port: mul_a / mul_b  output  16 each  operands to the shared single-cycle BF16 multiplier.
REQ-009 Port: mul_o  input  16  multiplier product, valid one cycle after the operands are driven.
REQ-010 Port: rsp_valid / rsp_ready  output / input  1 each  result handshake.
REQ-011 Port: rsp_data  output  16  BF16 product; rsp_id  output  clog2(N_REQ)  originating requester.
REQ-012 Port: busy  output  1  high when the state is not IDLE.
REQ-013 Port: perf_issue / perf_block  output  32 each  performance counters (see Configuration).

Function
REQ-014 Issue is permitted only when fifo_count + inflight < FIFO_DEPTH; inflight is a 1-bit register.
REQ-015 Arbitration is round-robin: the search starts at last_grant+1 modulo N_REQ, and the first requester with req_valid set wins.
REQ-016 req_ready is combinational; at most one bit is set, and only for a valid requester while issue is permitted.
REQ-017 On an issue in cycle t, mul_a and mul_b carry the winner's operands in cycle t, and inflight and inflight_id are set at the edge ending t.
REQ-018 In cycle t+1, mul_o and inflight_id are written into the FIFO at the edge ending t+1, so rsp_valid rises in cycle t+2 (minimum latency 2).
REQ-019 When no issue occurs, mul_a and mul_b are driven to 16'h0000.
REQ-020 The FIFO returns results in issue order; rsp_data and rsp_id come from the head entry.
REQ-021 A pop occurs when rsp_valid and rsp_ready are both high.
REQ-022 A simultaneous push and pop leaves fifo_count unchanged.
REQ-023 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 Throughput: with rsp_ready held high and any requester valid, one issue occurs per cycle.
REQ-025 Requester i holding req_valid high is granted within N_REQ issue slots.
REQ-026 last_grant updates only on an actual issue.
REQ-027 Multiplier result values pass through unmodified; the block performs no arithmetic on operands or results.
REQ-028 State machine states:
- IDLE: inflight=0, FIFO empty.
- ACTIVE: work pending and issue permitted.
- BLOCKED: issue not permitted due to the credit limit.
REQ-029 State transitions:
- IDLE->ACTIVE on any issue.
- ACTIVE->BLOCKED when the next-cycle credit check fails.
- BLOCKED->ACTIVE when a pop frees credit.
- ACTIVE->IDLE when the FIFO drains and inflight=0 with no issue.
REQ-030 While BLOCKED, req_ready is all zero and rsp_* continue to operate.

Reset
REQ-031 In a cycle with rst high, all state updates to reset values at the edge and takes priority over any handshake in that cycle.
REQ-032 Reset values:
- state=IDLE, inflight=0, FIFO pointers and count=0.
- last_grant=N_REQ-1, so requester 0 wins first.
- rsp_valid=0, busy=0, req_ready=0 while rst is high.
- perf_issue=perf_block=0.
REQ-033 A reset asserted mid-operation discards in-flight and queued results; no rsp_valid for them ever appears after reset.

Configuration
REQ-034 Macro BFP16_ARB_PERF_EN: when defined, perf_issue increments on each issue and perf_block increments each cycle in BLOCKED with any req_valid high; both wrap at 2^32.
REQ-035 Without BFP16_ARB_PERF_EN, perf_issue and perf_block are constant zero and no counter flops are implemented.

Verification
REQ-036 Single request: reset, then requester 2 presents A=16'h3F80 (1.0), B=16'h4000 (2.0) for one cycle with rsp_ready=1 -> in cycle t+2, rsp_valid=1, rsp_data=16'h4000, rsp_id=2.
REQ-037 Fairness: all 4 requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,..., one per cycle, rsp_id sequence matches.
REQ-038 Backpressure: rsp_ready=0, all requesters valid -> exactly 4 issues, then state=BLOCKED and req_ready=0; raising rsp_ready for 1 cycle -> exactly one further issue, with results in issue order.
REQ-039 Simultaneous push/pop: FIFO at 2 entries, rsp_ready=1, continuous issue -> fifo_count stays 2 and no result is dropped or duplicated over 16 cycles.
REQ-040 Mid-operation reset: 3 results queued plus 1 in flight, rst pulsed 1 cycle -> rsp_valid=0 thereafter, busy=0, and the next grant goes to requester 0.
REQ-041 With BFP16_ARB_PERF_EN defined, run the REQ-038 scenario for 10 blocked cycles -> perf_issue=4 and perf_block=10; without the macro, both read 0.

Source files
------------

// File: rtl/bfp16_mult_arbiter.sv
// Round-robin arbiter feeding one shared single-cycle BF16 multiplier, with an in-order result FIFO.
// Optional performance counters are enabled by defining BFP16_ARB_PERF_EN.
module bfp16_mult_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [16*N_REQ-1:0]      req_a,
  input  logic [16*N_REQ-1:0]      req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [15:0]              mul_a,
  output logic [15:0]              mul_b,
  input  logic [15:0]              mul_o,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     busy,
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_block
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_BLOCKED = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           inflight_q, inflight_d;
  logic [IDW-1:0] inflight_id_q, inflight_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  fifo_count_q, fifo_count_d;
  logic [15:0]    data_q [FIFO_DEPTH];
  logic [15:0]    data_d [FIFO_DEPTH];
  logic [IDW-1:0] id_q [FIFO_DEPTH];
  logic [IDW-1:0] id_d [FIFO_DEPTH];

  logic           found_s, issue_ok_s, issue_s, push_s, pop_s, credit_ok_next_s;
  logic [IDW-1:0] winner_s;

  // Credit is counted against both queued entries and the product still in the multiplier.
  assign issue_ok_s = ((SW'(fifo_count_q) + SW'(inflight_q)) < SW'(FIFO_DEPTH)) && !rst;
  assign issue_s    = issue_ok_s && found_s;
  assign push_s     = inflight_q;
  assign rsp_valid  = (fifo_count_q != {CW{1'b0}}) && !rst;
  assign pop_s      = rsp_valid && rsp_ready;
  assign rsp_data   = data_q[rd_ptr_q];
  assign rsp_id     = id_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE) && !rst;

  always_comb begin
    int idx;
    idx       = 0;
    found_s   = 1'b0;
    winner_s  = {IDW{1'b0}};
    req_ready = {N_REQ{1'b0}};
    mul_a     = 16'h0000;
    mul_b     = 16'h0000;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % N_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = IDW'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (issue_s && (winner_s == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[16*i +: 16];
        mul_b        = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    data_d        = data_q;
    id_d          = id_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    inflight_d    = issue_s;
    inflight_id_d = issue_s ? winner_s : inflight_id_q;
    last_grant_d  = issue_s ? winner_s : last_grant_q;
    if (push_s) begin
      data_d[wr_ptr_q] = mul_o;
      id_d[wr_ptr_q]   = inflight_id_q;
      wr_ptr_d         = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   fifo_count_d = fifo_count_q - {{(CW-1){1'b0}}, 1'b1};
      default: fifo_count_d = fifo_count_q;
    endcase
    credit_ok_next_s = (SW'(fifo_count_d) + SW'(inflight_d)) < SW'(FIFO_DEPTH);
    case (state_q)
      S_IDLE:    state_d = issue_s ? S_ACTIVE : S_IDLE;
      S_ACTIVE: begin
        if (!credit_ok_next_s) begin
          state_d = S_BLOCKED;
        end else if ((fifo_count_d == {CW{1'b0}}) && !inflight_d) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_BLOCKED: state_d = credit_ok_next_s ? S_ACTIVE : S_BLOCKED;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      inflight_q    <= 1'b0;
      inflight_id_q <= {IDW{1'b0}};
      last_grant_q  <= IDW'(N_REQ - 1);
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      fifo_count_q  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= 16'h0000;
        id_q[i]   <= {IDW{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      last_grant_q  <= last_grant_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      data_q        <= data_d;
      id_q          <= id_d;
    end
  end

`ifdef BFP16_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_block_q, perf_block_d;

  always_comb begin
    perf_issue_d = perf_issue_q + {31'd0, issue_s};
    perf_block_d = perf_block_q + {31'd0, (state_q == S_BLOCKED) && (|req_valid)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_q <= 32'd0;
      perf_block_q <= 32'd0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_block_q <= perf_block_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_block = perf_block_q;
`else
  assign perf_issue = 32'd0;
  assign perf_block = 32'd0;
`endif

endmodule

// File: tb/tb_bfp16_mult_arbiter.sv
// Directed bench for bfp16_mult_arbiter: per-cycle vector table plus backpressure, steady-state and reset sequences.
module tb_bfp16_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [15:0] mul_a, mul_b, mul_o;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [31:0] perf_issue, perf_block;

  int n_checks = 0;
  int n_errors = 0;

  bfp16_mult_arbiter #(.N_REQ(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .perf_issue(perf_issue), .perf_block(perf_block)
  );

  always #5 clk = ~clk;

  // Multiplier model: every requester sends A = 1.0, so the true product is B.
  always @(posedge clk) mul_o <= (mul_a == 16'h3F80) ? mul_b : 16'h7FC0;

  function automatic logic [15:0] b_of(input int i);
    case (i % 4)
      0:       return 16'h4040;
      1:       return 16'h4080;
      2:       return 16'h4000;
      default: return 16'h40A0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  e_ready;
    logic [15:0] e_mulb;
    logic        e_rv;
    logic [15:0] e_data;
    logic [1:0]  e_id;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rd, input logic [3:0] er,
                              input logic [15:0] mb, input logic rv, input logic [15:0] d,
                              input logic [1:0] id, input logic bz);
    vec_t x;
    x.rst = r; x.vld = v; x.rdy = rd; x.e_ready = er; x.e_mulb = mb;
    x.e_rv = rv; x.e_data = d; x.e_id = id; x.e_busy = bz;
    return x;
  endfunction

  vec_t vt[20];
  int   issues, k;
  int   exp_issue, exp_pop;
  logic [1:0] exp_ids[4];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0;
    req_a = {4{16'h3F80}};
    req_b = {16'h40A0, 16'h4000, 16'h4080, 16'h4040};

    vt[0]  = mk(1'b1, 4'hF,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[1]  = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[2]  = mk(1'b0, 4'b0100, 1'b1, 4'b0100, 16'h4000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[3]  = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1);
    vt[4]  = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b1, 16'h4000, 2'd2, 1'b1);
    vt[5]  = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[6]  = mk(1'b0, 4'hF,    1'b1, 4'b1000, 16'h40A0, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[7]  = mk(1'b0, 4'hF,    1'b1, 4'b0001, 16'h4040, 1'b0, 16'h0000, 2'd0, 1'b1);
    vt[8]  = mk(1'b0, 4'hF,    1'b1, 4'b0010, 16'h4080, 1'b1, 16'h40A0, 2'd3, 1'b1);
    vt[9]  = mk(1'b0, 4'hF,    1'b1, 4'b0100, 16'h4000, 1'b1, 16'h4040, 2'd0, 1'b1);
    vt[10] = mk(1'b0, 4'hF,    1'b1, 4'b1000, 16'h40A0, 1'b1, 16'h4080, 2'd1, 1'b1);
    vt[11] = mk(1'b0, 4'hF,    1'b1, 4'b0001, 16'h4040, 1'b1, 16'h4000, 2'd2, 1'b1);
    vt[12] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b1, 16'h40A0, 2'd3, 1'b1);
    vt[13] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b1, 16'h4040, 2'd0, 1'b1);
    vt[14] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[15] = mk(1'b0, 4'b0101, 1'b1, 4'b0100, 16'h4000, 1'b0, 16'h0000, 2'd0, 1'b0);
    vt[16] = mk(1'b0, 4'b0101, 1'b1, 4'b0001, 16'h4040, 1'b0, 16'h0000, 2'd0, 1'b1);
    vt[17] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b1, 16'h4000, 2'd2, 1'b1);
    vt[18] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b1, 16'h4040, 2'd0, 1'b1);
    vt[19] = mk(1'b0, 4'h0,    1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0);

    cyc();
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; req_valid = vt[i].vld; rsp_ready = vt[i].rdy;
      #2;
      chk($sformatf("vec%0d req_ready", i), {28'd0, req_ready}, {28'd0, vt[i].e_ready});
      chk($sformatf("vec%0d mul_b", i), {16'd0, mul_b}, {16'd0, vt[i].e_mulb});
      chk($sformatf("vec%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vt[i].e_rv});
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
      if (vt[i].e_rv) begin
        chk($sformatf("vec%0d rsp_data", i), {16'd0, rsp_data}, {16'd0, vt[i].e_data});
        chk($sformatf("vec%0d rsp_id", i), {30'd0, rsp_id}, {30'd0, vt[i].e_id});
      end
      cyc();
    end

    // Backpressure: four issues fill the credit, then ten blocked cycles.
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b0; issues = 0;
    for (int c = 0; c < 14; c++) begin
      #2;
      if (|req_ready) issues++;
      cyc();
    end
    #2;
    chk("bp issues", issues, 4);
    chk("bp blocked ready", {28'd0, req_ready}, 32'd0);
    chk("bp busy", {31'd0, busy}, 32'd1);
    chk("bp fifo_count", {29'd0, dut.fifo_count_q}, 32'd4);
`ifdef BFP16_ARB_PERF_EN
    chk("perf_issue", perf_issue, 32'd4);
    chk("perf_block", perf_block, 32'd10);
`else
    chk("perf_issue", perf_issue, 32'd0);
    chk("perf_block", perf_block, 32'd0);
`endif
    rsp_ready = 1'b1;
    #1;
    chk("bp pop valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp pop id", {30'd0, rsp_id}, 32'd0);
    chk("bp pop data", {16'd0, rsp_data}, {16'd0, b_of(0)});
    cyc();
    rsp_ready = 1'b0; issues = 0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (|req_ready) begin
        issues++;
        chk("bp extra grant", {28'd0, req_ready}, 32'd1);
      end
      cyc();
    end
    chk("bp extra issues", issues, 1);
    exp_ids[0] = 2'd1; exp_ids[1] = 2'd2; exp_ids[2] = 2'd3; exp_ids[3] = 2'd0;
    req_valid = 4'h0; rsp_ready = 1'b1; k = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (rsp_valid && k < 4) begin
        chk($sformatf("bp drain id%0d", k), {30'd0, rsp_id}, {30'd0, exp_ids[k]});
        chk($sformatf("bp drain data%0d", k), {16'd0, rsp_data}, {16'd0, b_of(int'(exp_ids[k]))});
        k++;
      end
      cyc();
    end
    chk("bp drain count", k, 4);

    // Steady state with two queued entries: push and pop in the same cycle.
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b0; exp_issue = 0; exp_pop = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("ss fill grant", {28'd0, req_ready}, 32'd1 << (exp_issue % 4));
      exp_issue++;
      cyc();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #2;
      chk("ss fifo_count", {29'd0, dut.fifo_count_q}, 32'd2);
      chk("ss grant", {28'd0, req_ready}, 32'd1 << (exp_issue % 4));
      exp_issue++;
      chk("ss rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("ss rsp_id", {30'd0, rsp_id}, exp_pop % 4);
      chk("ss rsp_data", {16'd0, rsp_data}, {16'd0, b_of(exp_pop)});
      exp_pop++;
      cyc();
    end
    req_valid = 4'h0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (rsp_valid) begin
        chk("ss drain id", {30'd0, rsp_id}, exp_pop % 4);
        exp_pop++;
      end
      cyc();
    end
    chk("ss total results", exp_pop, exp_issue);

    // Reset with three results queued and one product in flight.
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    #2;
    chk("mr queued", {29'd0, dut.fifo_count_q}, 32'd3);
    chk("mr inflight", {31'd0, dut.inflight_q}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr ready during rst", {28'd0, req_ready}, 32'd0);
    chk("mr rsp_valid during rst", {31'd0, rsp_valid}, 32'd0);
    chk("mr busy during rst", {31'd0, busy}, 32'd0);
    cyc();
    rst = 1'b0; req_valid = 4'h0; rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("mr rsp_valid after", {31'd0, rsp_valid}, 32'd0);
      chk("mr busy after", {31'd0, busy}, 32'd0);
      cyc();
    end
    req_valid = 4'hF;
    #2;
    chk("mr first grant", {28'd0, req_ready}, 32'd1);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
